noc_packet_injector: RTL

- Node-side network interface that drives a fabric local ingress port; it is the sender that feeds the fabric's per-node receiver flit port.
- Accepts a packet descriptor plus a stream of payload words from the local core.
- Allocates a virtual channel, then serialises the packet into head, body and tail flits using the valid/ready/vc_ready flit handshake.
- One instance per active node, outside the fabric.

---
 rtl/noc_packet_injector_pkg.sv | 31 +++
 rtl/noc_vc_rr_arbiter.sv | 42 ++++
 rtl/noc_packet_injector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/noc_packet_injector_pkg.sv
// Shared types for the NoC packet injector and the reusable VC round-robin arbiter.
package noc_packet_injector_pkg;

  localparam int unsigned NocIdXWidth = 4;
  localparam int unsigned NocIdYWidth = 4;
  localparam int unsigned NocLenWidth = 4;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } noc_flit_type_e;

  // Head flit payload, LSB-aligned in the flit data field.
  typedef struct packed {
    logic [NocIdXWidth-1:0] src_x;
    logic [NocIdYWidth-1:0] src_y;
    logic [NocIdXWidth-1:0] dst_x;
    logic [NocIdYWidth-1:0] dst_y;
    logic [NocLenWidth-1:0] len;
  } noc_head_t;

  typedef enum logic [1:0] {
    StIdle,
    StVcAlloc,
    StHead,
    StBody
  } inj_state_e;

endpackage

// File: rtl/noc_vc_rr_arbiter.sv
// Round-robin pick over VC_NUM requests; the search start advances past the granted index
// only when the grant is consumed (update).
module noc_vc_rr_arbiter #(
  parameter int unsigned  VC_NUM = 2,
  localparam int unsigned VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VC_NUM-1:0] req,
  input  logic              update,
  output logic              gnt_valid,
  output logic [VC_W-1:0]   gnt_idx
);

  logic [VC_W-1:0] ptr_q;
  logic [VC_W-1:0] cand_idx;
  int unsigned     cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      cand     = (32'(ptr_q) + i) % VC_NUM;
      cand_idx = VC_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (update && gnt_valid) begin
      ptr_q <= VC_W'((32'(gnt_idx) + 32'd1) % VC_NUM);
    end
  end

endmodule

// File: rtl/noc_packet_injector.sv
// Node-side NoC injector: descriptor + payload words in, head/body/tail flits out on one
// round-robin-allocated VC. Define NOC_INJECTOR_STATS_EN to add packet/flit counters.
module noc_packet_injector
  import noc_packet_injector_pkg::*;
#(
  parameter int unsigned  VC_NUM     = 2,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  LEN_WIDTH  = NocLenWidth,
  parameter int unsigned  ID_X_WIDTH = NocIdXWidth,
  parameter int unsigned  ID_Y_WIDTH = NocIdYWidth,
  localparam int unsigned VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int unsigned FLIT_WIDTH = 2 + VC_W + DATA_WIDTH
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic [ID_X_WIDTH-1:0] id_x,
  input  logic [ID_Y_WIDTH-1:0] id_y,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [ID_X_WIDTH-1:0] pkt_dst_x,
  input  logic [ID_Y_WIDTH-1:0] pkt_dst_y,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [VC_NUM-1:0]     out_vc_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  busy
`ifdef NOC_INJECTOR_STATS_EN
  ,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_flit_cnt
`endif
);

  inj_state_e            state_q, state_d;
  logic [ID_X_WIDTH-1:0] src_x_q, dst_x_q;
  logic [ID_Y_WIDTH-1:0] src_y_q, dst_y_q;
  logic [LEN_WIDTH-1:0]  len_q, remaining_q, remaining_d;
  logic [VC_W-1:0]       cur_vc_q, cur_vc_d, gnt_idx;
  logic                  gnt_valid, arb_update, pkt_accept, flit_xfer, out_valid_d;
  logic [FLIT_WIDTH-1:0] out_flit_d;
  logic [DATA_WIDTH-1:0] head_data;
  noc_flit_type_e        out_type;

  // Gated by reset so the descriptor port reads not-ready while reset is held.
  assign pkt_ready  = (state_q == StIdle) && noc_rst_n;
  assign pkt_accept = pkt_valid && pkt_ready;
  assign flit_xfer  = out_valid && out_ready;
  assign busy       = (state_q != StIdle);
  assign out_type   = noc_flit_type_e'(out_flit[FLIT_WIDTH-1 -: 2]);
  assign head_data  = DATA_WIDTH'({src_x_q, src_y_q, dst_x_q, dst_y_q, len_q});

  noc_vc_rr_arbiter #(
    .VC_NUM (VC_NUM)
  ) u_vc_arb (
    .clk       (noc_clk),
    .rst_n     (noc_rst_n),
    .req       (out_vc_ready),
    .update    (arb_update),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_vc_d    = cur_vc_q;
    out_valid_d = out_valid && !out_ready;
    out_flit_d  = out_flit;
    arb_update  = 1'b0;
    data_ready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pkt_accept) state_d = StVcAlloc;
      end
      StVcAlloc: begin
        if (gnt_valid) begin
          arb_update  = 1'b1;
          cur_vc_d    = gnt_idx;
          remaining_d = len_q;
          out_valid_d = 1'b1;
          out_flit_d  = {(len_q == '0) ? FLIT_SINGLE : FLIT_HEAD, gnt_idx, head_data};
          state_d     = StHead;
        end
      end
      StHead, StBody: begin
        // Payload may load while the head is leaving, keeping the stream at 1 flit/cycle.
        data_ready = out_vc_ready[cur_vc_q] && (!out_valid || out_ready) &&
                     (remaining_q != '0);
        if (data_ready && data_valid) begin
          out_valid_d = 1'b1;
          out_flit_d  = {(remaining_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY, cur_vc_q, data};
          remaining_d = remaining_q - LEN_WIDTH'(1);
        end
        if (state_q == StHead) begin
          if (flit_xfer) state_d = (len_q == '0) ? StIdle : StBody;
        end else if (flit_xfer && (out_type == FLIT_TAIL)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cur_vc_q    <= '0;
      out_valid   <= 1'b0;
      out_flit    <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_vc_q    <= cur_vc_d;
      out_valid   <= out_valid_d;
      out_flit    <= out_flit_d;
      if (pkt_accept) begin
        src_x_q <= id_x;
        src_y_q <= id_y;
        dst_x_q <= pkt_dst_x;
        dst_y_q <= pkt_dst_y;
        len_q   <= pkt_len;
      end
    end
  end

`ifdef NOC_INJECTOR_STATS_EN
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      stat_pkt_cnt  <= '0;
      stat_flit_cnt <= '0;
    end else if (flit_xfer) begin
      stat_flit_cnt <= stat_flit_cnt + 32'd1;
      if ((out_type == FLIT_TAIL) || (out_type == FLIT_SINGLE)) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
